// File: rtl/seq_operand_adder_pkg.sv
// Shared definitions for the sequential operand-entry adder: entry phase
// encodings and the constant functions that size the chunk index.
package seq_operand_adder_pkg;

    typedef enum logic [1:0] {
        PH_LOAD_A = 2'd0,
        PH_LOAD_B = 2'd1,
        PH_DONE   = 2'd2
    } phase_t;

    // Number of NIB-bit chunks needed to cover n bits.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Bits needed to index n items, never less than one so a single-chunk
    // build still has a real index port.
    function automatic int clog2_min1(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/seq_operand_adder_ripple.sv
// Ripple-carry adder built from single-bit full-adder cells. Subtraction is
// done by the caller: invert b and drive cin high.

// One-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

// WIDTH-bit ripple chain with signed overflow taken on the operands as seen
// by the adder (b already inverted for subtraction).
module ripple_add_n #(
    parameter int WIDTH = 7
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder u_fa (
            .a   (a[i]),
            .b   (b[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    assign cout = c[WIDTH];
    assign ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (s[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/seq_operand_adder.sv
// Push-button operand-entry adder. Operands A and B are entered NIB bits at a
// time (A chunks first, then B chunks); in DONE the sum/difference, carry,
// signed overflow and valid are registered every cycle.
// Optional build macro SEQ_ADDER_DEBOUNCE_EN adds a DBNC_CYCLES-cycle
// debouncer between each button synchroniser and its edge detector.
module seq_operand_adder
    import seq_operand_adder_pkg::*;
#(
    parameter int  WIDTH       = 7,
    parameter int  NIB         = 4,
    parameter int  DBNC_CYCLES = 16,
    localparam int CHUNKS      = ceil_div(WIDTH, NIB),
    localparam int IDX_W       = clog2_min1(CHUNKS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_btn,
    input  logic             clr_btn,
    input  logic [NIB-1:0]   entry,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             ovf,
    output logic             valid,
    output logic [1:0]       phase,
    output logic [IDX_W-1:0] chunk_idx
);

    // Replace chunk idx of op with val; bits past WIDTH-1 simply have no
    // destination and are dropped.
    function automatic logic [WIDTH-1:0] write_chunk(input logic [WIDTH-1:0] op,
                                                     input logic [IDX_W-1:0] idx,
                                                     input logic [NIB-1:0]   val);
        logic [WIDTH-1:0] r;
        r = op;
        for (int i = 0; i < WIDTH; i++) begin
            if ((i / NIB) == int'(idx)) r[i] = val[i % NIB];
        end
        return r;
    endfunction

    // Button conditioning: bit 0 = load, bit 1 = clear.
    logic [1:0] btn_raw;
    logic [1:0] btn_pulse;
    logic       ld_p;
    logic       cl_p;

    assign btn_raw = {clr_btn, load_btn};
    assign ld_p    = btn_pulse[0];
    assign cl_p    = btn_pulse[1];

    for (genvar g = 0; g < 2; g++) begin : g_btn
        logic [1:0] sync;
        logic       lvl;
        logic       lvl_d;

        // Two-flop synchroniser for the asynchronous button.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) sync <= '0;
            else        sync <= {sync[0], btn_raw[g]};
        end

`ifdef SEQ_ADDER_DEBOUNCE_EN
        localparam int DBNC_W = $clog2(DBNC_CYCLES + 1);
        logic [DBNC_W-1:0] cnt;

        // Level follows the synchronised input only after it has differed for
        // DBNC_CYCLES consecutive cycles; any return to the old level restarts.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                lvl <= 1'b0;
            end else if (sync[1] == lvl) begin
                cnt <= '0;
            end else if (cnt == DBNC_W'(DBNC_CYCLES - 1)) begin
                cnt <= '0;
                lvl <= sync[1];
            end else begin
                cnt <= cnt + DBNC_W'(1);
            end
        end
`else
        assign lvl = sync[1];
`endif

        // Previous level for rising-edge detection; one pulse per press.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) lvl_d <= 1'b0;
            else        lvl_d <= lvl;
        end

        assign btn_pulse[g] = lvl & ~lvl_d;
    end

    // Entry state and result registers.
    phase_t           phase_q, phase_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d, ovf_q, ovf_d, valid_q, valid_d;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] add_s;
    logic             add_c;
    logic             add_v;
    logic             last_chunk;

    assign b_eff      = sub ? ~b_q : b_q;
    assign last_chunk = (idx_q == IDX_W'(CHUNKS - 1));

    ripple_add_n #(.WIDTH(WIDTH)) u_add (
        .a   (a_q),
        .b   (b_eff),
        .cin (sub),
        .s   (add_s),
        .cout(add_c),
        .ovf (add_v)
    );

    // State register for the entry FSM and the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q <= PH_LOAD_A;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            phase_q <= phase_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    // Next-state: chunk writes, phase sequencing, clear priority, result capture.
    always_comb begin
        phase_d = phase_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;

        if (cl_p) begin
            phase_d = PH_LOAD_A;
            idx_d   = '0;
            a_d     = '0;
            b_d     = '0;
            sum_d   = '0;
            carry_d = 1'b0;
            ovf_d   = 1'b0;
        end else begin
            case (phase_q)
                PH_LOAD_A: begin
                    if (ld_p) begin
                        a_d = write_chunk(a_q, idx_q, entry);
                        if (last_chunk) begin
                            phase_d = PH_LOAD_B;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                PH_LOAD_B: begin
                    if (ld_p) begin
                        b_d = write_chunk(b_q, idx_q, entry);
                        if (last_chunk) begin
                            phase_d = PH_DONE;
                            idx_d   = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                PH_DONE: begin
                    if (ld_p) begin
                        // A new press starts a fresh pair; result regs hold.
                        a_d = write_chunk('0, '0, entry);
                        b_d = '0;
                        if (CHUNKS == 1) begin
                            phase_d = PH_LOAD_B;
                            idx_d   = '0;
                        end else begin
                            phase_d = PH_LOAD_A;
                            idx_d   = IDX_W'(1);
                        end
                    end else begin
                        sum_d   = add_s;
                        carry_d = add_c;
                        ovf_d   = add_v;
                        valid_d = 1'b1;
                    end
                end
                default: begin
                    phase_d = PH_LOAD_A;
                    idx_d   = '0;
                end
            endcase
        end
    end

    assign sum       = sum_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign valid     = valid_q;
    assign phase     = phase_q;
    assign chunk_idx = idx_q;

endmodule

// File: tb/tb_seq_operand_adder.sv
// Self-checking bench for seq_operand_adder (WIDTH=7, NIB=4). Expected values
// come from a plain-arithmetic model of operand entry and signed add/sub.
module tb_seq_operand_adder;

    localparam int WIDTH       = 7;
    localparam int NIB         = 4;
    localparam int DBNC_CYCLES = 16;
    localparam int CHUNKS      = 2;
    localparam int IDX_W       = 1;
`ifdef SEQ_ADDER_DEBOUNCE_EN
    localparam int LAT = 2 + DBNC_CYCLES;
`else
    localparam int LAT = 2;
`endif
    localparam int HOLD = LAT + 2;
    localparam int GAP  = LAT + 3;
    localparam int OBS_W = 2 + IDX_W + 3 + WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             load_btn = 1'b0;
    logic             clr_btn = 1'b0;
    logic             sub = 1'b0;
    logic [NIB-1:0]   entry = '0;
    logic [WIDTH-1:0] sum;
    logic             carry, ovf, valid;
    logic [1:0]       phase;
    logic [IDX_W-1:0] chunk_idx;

    // Observed bundle: {phase, chunk_idx, valid, carry, ovf, sum}
    logic [OBS_W-1:0] obs;
    logic [OBS_W-1:0] exp_v;
    assign obs = {phase, chunk_idx, valid, carry, ovf, sum};

    int errors = 0;
    int checks = 0;

    seq_operand_adder #(.WIDTH(WIDTH), .NIB(NIB), .DBNC_CYCLES(DBNC_CYCLES)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_btn (load_btn),
        .clr_btn  (clr_btn),
        .entry    (entry),
        .sub      (sub),
        .sum      (sum),
        .carry    (carry),
        .ovf      (ovf),
        .valid    (valid),
        .phase    (phase),
        .chunk_idx(chunk_idx)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    int               m_a, m_b, m_phase, m_idx;
    logic [WIDTH+1:0] m_held;   // {carry, ovf, sum} shown outside DONE

    // {carry, ovf, sum} from integer arithmetic on the operand values.
    function automatic logic [WIDTH+1:0] ref_result(input int a, input int b, input logic s);
        int modv, half, full, sa, sb, ideal;
        logic [WIDTH+1:0] r;
        modv  = 1 << WIDTH;
        half  = 1 << (WIDTH - 1);
        full  = s ? (a - b + modv) : (a + b);
        sa    = (a >= half) ? a - modv : a;
        sb    = (b >= half) ? b - modv : b;
        ideal = s ? (sa - sb) : (sa + sb);
        r[WIDTH-1:0] = WIDTH'(full % modv);
        r[WIDTH+1]   = (full >= modv);
        r[WIDTH]     = (ideal >= half) || (ideal < -half);
        return r;
    endfunction

    function automatic logic [OBS_W-1:0] model_expect(input logic s);
        logic [WIDTH+1:0] r;
        logic             v;
        if (m_phase == 2) begin
            r = ref_result(m_a, m_b, s);
            v = 1'b1;
        end else begin
            r = m_held;
            v = 1'b0;
        end
        return {2'(m_phase), IDX_W'(m_idx), v, r[WIDTH+1], r[WIDTH], r[WIDTH-1:0]};
    endfunction

    task automatic model_clear();
        m_a = 0; m_b = 0; m_phase = 0; m_idx = 0; m_held = '0;
    endtask

    task automatic model_load(input int e, input logic s);
        int sh, mask, full;
        sh   = m_idx * NIB;
        mask = ((1 << NIB) - 1) << sh;
        full = (1 << WIDTH) - 1;
        if (m_phase == 2) begin
            m_held = ref_result(m_a, m_b, s);
            m_a = e & full;
            m_b = 0;
            if (CHUNKS == 1) begin m_phase = 1; m_idx = 0; end
            else begin m_phase = 0; m_idx = 1; end
        end else begin
            if (m_phase == 0) m_a = ((m_a & ~mask) | (e << sh)) & full;
            else              m_b = ((m_b & ~mask) | (e << sh)) & full;
            if (m_idx == CHUNKS - 1) begin m_idx = 0; m_phase = m_phase + 1; end
            else m_idx = m_idx + 1;
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic press(input int e);
        @(negedge clk);
        entry = NIB'(e);
        load_btn = 1'b1;
        repeat (HOLD) @(negedge clk);
        load_btn = 1'b0;
        repeat (GAP) @(negedge clk);
        model_load(e, sub);
    endtask

    task automatic press_clr();
        @(negedge clk);
        clr_btn = 1'b1;
        repeat (HOLD) @(negedge clk);
        clr_btn = 1'b0;
        repeat (GAP) @(negedge clk);
        model_clear();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_held: got %h want %h", obs, {OBS_W{1'b0}});
        end
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        model_clear();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL reset_release: got %h want %h", obs, {OBS_W{1'b0}});
        end
    endtask

    task automatic test_add_basic();
        press(5);
        press(4);
        press(4'hA);
        @(negedge clk);
        entry = 4'h3;
        load_btn = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL add_prewrite: got %h want %h", obs, exp_v);
        end
        @(posedge clk);
        #1;
        exp_v = {2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 7'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL add_enter_done: got %h want %h", obs, exp_v);
        end
        @(posedge clk);
        #1;
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'h7F};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL add_result: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        load_btn = 1'b0;
        repeat (GAP) @(negedge clk);
        model_load(3, sub);
    endtask

    task automatic test_overflow();
        press(4'hF); press(7); press(1); press(0);
        exp_v = {2'd2, 1'b0, 1'b1, 1'b1, 1'b0, 7'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL add_carry: got %h want %h", obs, exp_v);
        end
        press(4'hF); press(3); press(1); press(0);
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b1, 7'h40};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL add_ovf: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_sub_toggle();
        @(negedge clk);
        sub = 1'b1;
        press(5); press(0); press(7); press(0);
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'h7E};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL sub_result: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        sub = 1'b0;
        #1;
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL sub_toggle_early: got %h want %h", obs, exp_v);
        end
        @(posedge clk);
        #1;
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'h0C};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL sub_toggle_add: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_upper_chunk();
        press_clr();
        press(0); press(4'hF); press(0); press(0);
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'h70};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL upper_chunk: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_hold();
        press_clr();
        @(negedge clk);
        entry = 4'h9;
        load_btn = 1'b1;
        repeat (50) @(negedge clk);
        load_btn = 1'b0;
        repeat (GAP) @(negedge clk);
        model_load(9, sub);
        exp_v = {2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 7'h00};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_single_write: got %h want %h", obs, exp_v);
        end
        press(2); press(1); press(0);
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'h2A};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL hold_sum: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_clear();
        press(3); press(1); press(6);
        exp_v = {2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 7'h2A};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL clear_pre: got %h want %h", obs, exp_v);
        end
        press_clr();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL clear_mid_b: got %h want %h", obs, {OBS_W{1'b0}});
        end
        press(4);
        @(negedge clk);
        entry = 4'hE;
        load_btn = 1'b1;
        clr_btn = 1'b1;
        repeat (HOLD) @(negedge clk);
        load_btn = 1'b0;
        clr_btn = 1'b0;
        repeat (GAP) @(negedge clk);
        model_clear();
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL clear_beats_load: got %h want %h", obs, {OBS_W{1'b0}});
        end
        press(1); press(0); press(2); press(0);
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'h03};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL clear_then_add: got %h want %h", obs, exp_v);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                press_clr();
            end else begin
                if ($urandom_range(0, 3) == 0) begin
                    @(negedge clk);
                    sub = 1'($urandom_range(0, 1));
                end
                press(int'($urandom_range(0, 15)));
            end
            exp_v = model_expect(sub);
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL random_step%0d: got %h want %h", i, obs, exp_v);
            end
        end
    endtask

    task automatic test_async_reset();
        press_clr();
        @(negedge clk);
        sub = 1'b0;
        press(6); press(2); press(3); press(1);
        press(5);
        exp_v = model_expect(sub);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL areset_pre: got %h want %h", obs, exp_v);
        end
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL areset_async: got %h want %h", obs, {OBS_W{1'b0}});
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_clear();
        press(7); press(0); press(1); press(0);
        exp_v = {2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 7'h08};
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL areset_after: got %h want %h", obs, exp_v);
        end
    endtask

`ifdef SEQ_ADDER_DEBOUNCE_EN
    task automatic test_debounce();
        press_clr();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            entry = 4'hB;
            load_btn = 1'b1;
            repeat (3) @(negedge clk);
            load_btn = 1'b0;
            repeat (6) @(negedge clk);
        end
        repeat (DBNC_CYCLES + 5) @(negedge clk);
        checks++;
        if (obs !== '0) begin
            errors++;
            $display("FAIL dbnc_glitch: got %h want %h", obs, {OBS_W{1'b0}});
        end
        @(negedge clk);
        load_btn = 1'b1;
        repeat (LAT) @(posedge clk);
        #1;
        checks++;
        if (chunk_idx !== 1'b0) begin
            errors++;
            $display("FAIL dbnc_prewrite: got %0d want 0", chunk_idx);
        end
        @(posedge clk);
        #1;
        checks++;
        if (chunk_idx !== 1'b1) begin
            errors++;
            $display("FAIL dbnc_write: got %0d want 1", chunk_idx);
        end
        @(negedge clk);
        load_btn = 1'b0;
        repeat (GAP) @(negedge clk);
        model_load(4'hB, sub);
    endtask
`endif

    initial begin
        test_reset();
        test_add_basic();
        test_overflow();
        test_sub_toggle();
        test_upper_chunk();
        test_hold();
        test_clear();
        test_random();
        test_async_reset();
`ifdef SEQ_ADDER_DEBOUNCE_EN
        test_debounce();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: run did not complete, errors=%0d", errors);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1);
    end

endmodule
